// File: rtl/sprite_scan.sv
// sprite_scan: per-scanline sprite evaluation in front of the sprite attribute BRAM.
// Walks every sprite index once per line_start and tests whether it covers the scanline.
// Each hit goes into a small FIFO that the fetch stage drains over valid/ready.
// Optional build macro SPRITE_SCAN_END_MARKER_EN: an all-ones y/height word ends the
// sprite list. When the macro is undefined, that word is treated as an ordinary sprite.

package sprite_scan_pkg;
    typedef struct packed {
        logic [11:0] y;
        logic [11:0] height;
    } sprite_y_height_t;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] width;
    } sprite_x_width_t;

    typedef logic [31:0] sprite_addr_t;
endpackage

module sprite_scan
    import sprite_scan_pkg::*;
#(
    parameter int NUM_SPRITES  = 512,
    parameter int MAX_PER_LINE = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int LINE_BITS    = 12
) (
    input  logic                 clk_draw,
    input  logic                 rst_draw,
    input  logic                 line_start,
    input  logic [LINE_BITS-1:0] scanline,
    output logic [8:0]           sprite_index,
    input  sprite_y_height_t     sprite_y_height,
    input  sprite_x_width_t      sprite_x_width,
    input  sprite_addr_t         sprite_addr,
    output logic                 hit_valid,
    input  logic                 hit_ready,
    output logic [8:0]           hit_index,
    output logic [LINE_BITS-1:0] hit_row,
    output sprite_x_width_t      hit_x_width,
    output sprite_addr_t         hit_addr,
    output logic                 scan_busy,
    output logic                 scan_done,
    output logic                 overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int HC_W  = $clog2(MAX_PER_LINE + 1);
    localparam logic [8:0]     IDX_LAST  = 9'(NUM_SPRITES - 1);
    localparam logic [HC_W-1:0] HIT_CAP  = HC_W'(MAX_PER_LINE);
    localparam logic [CNT_W:0]  OCC_FULL = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [8:0]           index;
        logic [LINE_BITS-1:0] row;
        sprite_x_width_t      xw;
        sprite_addr_t         addr;
    } hit_entry_t;

    state_t state_q, state_d;
    logic   scan_busy_q, scan_busy_d;
    logic   scan_done_q, scan_done_d;

    logic [LINE_BITS-1:0] scanline_q, scanline_d;
    logic [8:0]           idx_q, idx_d;
    logic                 issue_done_q, issue_done_d;
    logic                 pipe_valid_q, pipe_valid_d;
    logic [8:0]           pipe_idx_q, pipe_idx_d;
    logic [HC_W-1:0]      hit_cnt_q, hit_cnt_d;
    logic                 overflow_q, overflow_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     fifo_cnt_q, fifo_cnt_d;
    hit_entry_t           fifo_mem_q [FIFO_DEPTH];

    logic [LINE_BITS-1:0] row_s;
    logic [LINE_BITS-1:0] height_s;
    logic                 hit_s;
    logic                 marker_s;
    logic [CNT_W:0]       occ_s;
    logic                 stall_s;
    logic                 eval_s;
    logic                 hit_eval_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 ovf_s;
    logic                 term_s;
    logic                 issue_s;
    logic                 hit_valid_s;
    hit_entry_t           new_entry_s;
    hit_entry_t           head_s;

    // Hit test on the word returned for the in-flight index, plus scan control qualifiers
    always_comb begin
        row_s      = scanline_q - sprite_y_height.y[LINE_BITS-1:0];
        height_s   = sprite_y_height.height[LINE_BITS-1:0];
        hit_s      = (height_s != '0) && (row_s < height_s);
`ifdef SPRITE_SCAN_END_MARKER_EN
        marker_s   = &sprite_y_height;
`else
        marker_s   = 1'b0;
`endif
        occ_s      = {1'b0, fifo_cnt_q} + (CNT_W + 1)'(pipe_valid_q);
        // Never issue a read whose result might find the FIFO full
        stall_s    = (occ_s >= OCC_FULL);
        eval_s     = (state_q == ST_SCAN) && pipe_valid_q;
        hit_eval_s = eval_s && hit_s && !marker_s;
        push_s     = hit_eval_s && (hit_cnt_q != HIT_CAP);
        ovf_s      = hit_eval_s && (hit_cnt_q == HIT_CAP);
        term_s     = ovf_s || (eval_s && marker_s) || (eval_s && (pipe_idx_q == IDX_LAST));
        issue_s    = (state_q == ST_SCAN) && !stall_s && !issue_done_q && !term_s;
        hit_valid_s = (fifo_cnt_q != '0);
        pop_s      = hit_valid_s && hit_ready;

        new_entry_s.index = pipe_idx_q;
        new_entry_s.row   = row_s;
        new_entry_s.xw    = sprite_x_width;
        new_entry_s.addr  = sprite_addr;
    end

    // FSM state register with registered busy/done flags
    always_ff @(posedge clk_draw) begin
        if (rst_draw) begin
            state_q     <= ST_IDLE;
            scan_busy_q <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            scan_busy_q <= scan_busy_d;
            scan_done_q <= scan_done_d;
        end
    end

    // FSM next state: line_start always (re)starts a scan, even mid-scan
    always_comb begin
        state_d = state_q;
        if (line_start) begin
            state_d = ST_SCAN;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_SCAN: begin
                    if (term_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs, computed from the next state so the flags line up with it
    always_comb begin
        scan_busy_d = 1'b0;
        scan_done_d = 1'b0;
        case (state_d)
            ST_SCAN: scan_busy_d = 1'b1;
            ST_DONE: scan_done_d = 1'b1;
            default: begin
                scan_busy_d = 1'b0;
                scan_done_d = 1'b0;
            end
        endcase
    end

    // Datapath next state: address walk, read pipe, hit counter and FIFO pointers
    always_comb begin
        scanline_d   = scanline_q;
        idx_d        = idx_q;
        issue_done_d = issue_done_q;
        pipe_valid_d = 1'b0;
        pipe_idx_d   = pipe_idx_q;
        hit_cnt_d    = hit_cnt_q;
        overflow_d   = overflow_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_cnt_d   = fifo_cnt_q;
        if (line_start) begin
            // New line: restart the walk and discard everything queued for the old line
            scanline_d   = scanline;
            idx_d        = 9'd0;
            issue_done_d = 1'b0;
            hit_cnt_d    = '0;
            overflow_d   = 1'b0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            fifo_cnt_d   = '0;
        end else begin
            if (issue_s) begin
                pipe_valid_d = 1'b1;
                pipe_idx_d   = idx_q;
                if (idx_q == IDX_LAST) begin
                    issue_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + 9'd1;
                end
            end else begin
                pipe_valid_d = 1'b0;
            end

            if (push_s) begin
                hit_cnt_d = hit_cnt_q + HC_W'(1);
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            end else begin
                hit_cnt_d = hit_cnt_q;
            end

            if (ovf_s) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end

            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end

            case ({push_s, pop_s})
                2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
                2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
                default: fifo_cnt_d = fifo_cnt_q;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk_draw) begin
        if (rst_draw) begin
            scanline_q   <= '0;
            idx_q        <= 9'd0;
            issue_done_q <= 1'b0;
            pipe_valid_q <= 1'b0;
            pipe_idx_q   <= 9'd0;
            hit_cnt_q    <= '0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
        end else begin
            scanline_q   <= scanline_d;
            idx_q        <= idx_d;
            issue_done_q <= issue_done_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_idx_q   <= pipe_idx_d;
            hit_cnt_q    <= hit_cnt_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
        end
    end

    // FIFO storage: write the tested hit at the write pointer
    always_ff @(posedge clk_draw) begin
        if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= new_entry_s;
        end
    end

    // Head-of-FIFO presentation, forced to zero while the FIFO is empty
    always_comb begin
        head_s = fifo_mem_q[rd_ptr_q];
        if (hit_valid_s) begin
            hit_index   = head_s.index;
            hit_row     = head_s.row;
            hit_x_width = head_s.xw;
            hit_addr    = head_s.addr;
        end else begin
            hit_index   = 9'd0;
            hit_row     = '0;
            hit_x_width = '0;
            hit_addr    = '0;
        end
    end

    assign sprite_index = idx_q;
    assign hit_valid    = hit_valid_s;
    assign scan_busy    = scan_busy_q;
    assign scan_done    = scan_done_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_sprite_scan.sv
// Directed self-checking bench for sprite_scan with a one-cycle-latency BRAM model.
module tb_sprite_scan;
    import sprite_scan_pkg::*;

    logic             clk_draw = 1'b0;
    logic             rst_draw;
    logic             line_start;
    logic [11:0]      scanline;
    logic [8:0]       sprite_index;
    sprite_y_height_t sprite_y_height;
    sprite_x_width_t  sprite_x_width;
    sprite_addr_t     sprite_addr;
    logic             hit_valid;
    logic             hit_ready;
    logic [8:0]       hit_index;
    logic [11:0]      hit_row;
    sprite_x_width_t  hit_x_width;
    sprite_addr_t     hit_addr;
    logic             scan_busy;
    logic             scan_done;
    logic             overflow;

    sprite_scan dut (
        .clk_draw        (clk_draw),
        .rst_draw        (rst_draw),
        .line_start      (line_start),
        .scanline        (scanline),
        .sprite_index    (sprite_index),
        .sprite_y_height (sprite_y_height),
        .sprite_x_width  (sprite_x_width),
        .sprite_addr     (sprite_addr),
        .hit_valid       (hit_valid),
        .hit_ready       (hit_ready),
        .hit_index       (hit_index),
        .hit_row         (hit_row),
        .hit_x_width     (hit_x_width),
        .hit_addr        (hit_addr),
        .scan_busy       (scan_busy),
        .scan_done       (scan_done),
        .overflow        (overflow)
    );

    always #5 clk_draw = ~clk_draw;

    // Attribute BRAM model: registered read, data one cycle after address
    sprite_y_height_t mem_yh [512];
    sprite_x_width_t  mem_xw [512];
    sprite_addr_t     mem_ad [512];

    always @(posedge clk_draw) begin
        sprite_y_height <= mem_yh[sprite_index];
        sprite_x_width  <= mem_xw[sprite_index];
        sprite_addr     <= mem_ad[sprite_index];
    end

    int pass_cnt = 0;
    int total_cnt = 0;
    int n_cyc = 0;
    int done_cnt = 0;
    int done_n = 0;
    int first_valid_n = 0;
    int rx_idx [$];
    int rx_row [$];
    logic [31:0] rx_xw [$];
    logic [31:0] rx_ad [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) begin
            mem_yh[i] = '0;
            mem_xw[i] = '0;
            mem_ad[i] = '0;
        end
    endtask

    task automatic set_spr(input int idx, input int y, input int h);
        mem_yh[idx].y      = 12'(y);
        mem_yh[idx].height = 12'(h);
        mem_xw[idx].x      = 16'(256 + idx);
        mem_xw[idx].width  = 16'h0020;
        mem_ad[idx]        = 32'hA000_0000 + 32'(idx);
    endtask

    task automatic clear_records();
        rx_idx.delete();
        rx_row.delete();
        rx_xw.delete();
        rx_ad.delete();
        done_cnt = 0;
        done_n = 0;
        first_valid_n = 0;
    endtask

    // One clock: log a pop that the coming edge performs, then observe the new cycle
    task automatic step();
        if (hit_valid && hit_ready) begin
            rx_idx.push_back(int'(hit_index));
            rx_row.push_back(int'(hit_row));
            rx_xw.push_back(hit_x_width);
            rx_ad.push_back(hit_addr);
        end
        @(posedge clk_draw);
        #1;
        n_cyc = n_cyc + 1;
        if (scan_done) begin
            done_cnt = done_cnt + 1;
            done_n = n_cyc;
        end
        if (hit_valid && first_valid_n == 0) first_valid_n = n_cyc;
    endtask

    // Pulse line_start for one cycle; afterwards the bench sits in cycle T+1
    task automatic start_line(input logic [11:0] l);
        scanline = l;
        line_start = 1'b1;
        @(posedge clk_draw);
        #1;
        line_start = 1'b0;
        n_cyc = 1;
        first_valid_n = 0;
    endtask

    task automatic run_to_done(input string tag, input int budget);
        while (!(done_cnt > 0 && !hit_valid) && n_cyc < budget) step();
        check({tag, " within budget"}, 64'(n_cyc < budget), 64'd1);
    endtask

    initial begin
        rst_draw = 1'b1;
        line_start = 1'b0;
        scanline = 12'd0;
        hit_ready = 1'b1;
        clear_mem();

        // Reset, with a line_start overlapping the final reset cycle
        repeat (2) @(posedge clk_draw);
        #1;
        line_start = 1'b1;
        scanline = 12'd7;
        @(posedge clk_draw);
        #1;
        rst_draw = 1'b0;
        line_start = 1'b0;
        check("rst hit_valid", 64'(hit_valid), 64'd0);
        check("rst sprite_index", 64'(sprite_index), 64'd0);
        check("rst scan_busy", 64'(scan_busy), 64'd0);
        check("rst scan_done", 64'(scan_done), 64'd0);
        check("rst overflow", 64'(overflow), 64'd0);
        check("rst hit fields", {hit_index, hit_row, hit_x_width}, 64'd0);
        check("rst hit_addr", 64'(hit_addr), 64'd0);
        repeat (3) step();
        check("reset wins over line_start", 64'(scan_busy), 64'd0);

        // Single hit at sprite 3; sprite 7 above the line wraps to a large row
        clear_mem();
        set_spr(3, 10, 8);
        set_spr(7, 20, 4);
        clear_records();
        start_line(12'd15);
        check("s1 index at T+1", 64'(sprite_index), 64'd0);
        check("s1 busy", 64'(scan_busy), 64'd1);
        run_to_done("s1", 800);
        check("s1 hit count", 64'(rx_idx.size()), 64'd1);
        if (rx_idx.size() == 1) begin
            check("s1 hit index", 64'(rx_idx[0]), 64'd3);
            check("s1 hit row", 64'(rx_row[0]), 64'd5);
            check("s1 hit x_width", 64'(rx_xw[0]), 64'h0103_0020);
            check("s1 hit addr", 64'(rx_ad[0]), 64'hA000_0003);
        end
        check("s1 done cycle", 64'(done_n), 64'd514);
        check("s1 overflow", 64'(overflow), 64'd0);
        step();
        check("s1 done is a pulse", 64'(scan_done), 64'd0);
        check("s1 busy after", 64'(scan_busy), 64'd0);

        // Clipping at the top: y=4090 spans lines 4090..4095 and 0..3
        clear_mem();
        set_spr(0, 4090, 10);
        clear_records();
        start_line(12'd2);
        run_to_done("s4a", 800);
        check("s4 first hit_valid cycle", 64'(first_valid_n), 64'd3);
        check("s4 line2 count", 64'(rx_idx.size()), 64'd1);
        if (rx_row.size() == 1) check("s4 line2 row", 64'(rx_row[0]), 64'd8);
        clear_records();
        start_line(12'd4);
        run_to_done("s4b", 800);
        check("s4 line4 count", 64'(rx_idx.size()), 64'd0);

        // Too many sprites on one line
        clear_mem();
        for (int i = 0; i < 20; i++) set_spr(i, 0, 16);
        clear_records();
        start_line(12'd5);
        run_to_done("s2", 800);
        check("s2 hit count", 64'(rx_idx.size()), 64'd16);
        for (int i = 0; i < rx_idx.size() && i < 16; i++)
            check("s2 entry idx/row", {32'(rx_idx[i]), 32'(rx_row[i])}, {32'(i), 32'd5});
        check("s2 done cycle", 64'(done_n), 64'd19);
        check("s2 overflow", 64'(overflow), 64'd1);

        // Same line with the consumer stalled for 100 cycles
        clear_records();
        hit_ready = 1'b0;
        start_line(12'd5);
        while (n_cyc < 50) step();
        check("s3 stalled index", 64'(sprite_index), 64'd4);
        check("s3 head valid", 64'(hit_valid), 64'd1);
        check("s3 head index", 64'(hit_index), 64'd0);
        while (n_cyc < 100) step();
        check("s3 index held", 64'(sprite_index), 64'd4);
        check("s3 busy while stalled", 64'(scan_busy), 64'd1);
        hit_ready = 1'b1;
        run_to_done("s3", 1000);
        check("s3 hit count", 64'(rx_idx.size()), 64'd16);
        for (int i = 0; i < rx_idx.size() && i < 16; i++)
            check("s3 entry idx/row", {32'(rx_idx[i]), 32'(rx_row[i])}, {32'(i), 32'd5});
        check("s3 overflow", 64'(overflow), 64'd1);

        // Abort a scan around index 200 with two unread hits
        clear_mem();
        set_spr(50, 0, 16);
        set_spr(60, 0, 16);
        clear_records();
        hit_ready = 1'b0;
        start_line(12'd5);
        check("s5 overflow cleared", 64'(overflow), 64'd0);
        while (sprite_index != 9'd200 && n_cyc < 400) step();
        check("s5 reached index 200", 64'(sprite_index), 64'd200);
        check("s5 head before abort", {63'd0, hit_valid} | (64'(hit_index) << 1), 64'd101);
        start_line(12'd5);
        check("s5 flushed", 64'(hit_valid), 64'd0);
        check("s5 restart index", 64'(sprite_index), 64'd0);
        hit_ready = 1'b1;
        run_to_done("s5", 800);
        repeat (3) step();
        check("s5 single scan_done", 64'(done_cnt), 64'd1);
        check("s5 hit count", 64'(rx_idx.size()), 64'd2);
        if (rx_idx.size() == 2)
            check("s5 hit indices", {32'(rx_idx[0]), 32'(rx_idx[1])}, {32'd50, 32'd60});

        // All-ones word at sprite 5, ordinary hit at sprite 9
        clear_mem();
        mem_yh[5] = '1;
        mem_xw[5] = 32'h1234_5678;
        mem_ad[5] = 32'hDEAD_0005;
        set_spr(9, 0, 16);
        clear_records();
        start_line(12'd5);
        run_to_done("s6", 800);
`ifdef SPRITE_SCAN_END_MARKER_EN
        check("s6 marker hit count", 64'(rx_idx.size()), 64'd0);
        check("s6 marker done cycle", 64'(done_n), 64'd8);
`else
        check("s6 hit count", 64'(rx_idx.size()), 64'd2);
        if (rx_idx.size() == 2) begin
            check("s6 first idx/row", {32'(rx_idx[0]), 32'(rx_row[0])}, {32'd5, 32'd6});
            check("s6 second idx/row", {32'(rx_idx[1]), 32'(rx_row[1])}, {32'd9, 32'd5});
        end
        check("s6 done cycle", 64'(done_n), 64'd514);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
